// File: rtl/race_controller.sv
// race_controller: race-level sequencer for the two-player racer.
// Walks IDLE -> 3-2-1 countdown -> RACING -> FINISH, counts checkpoint-armed
// laps per player from world coordinates, and keeps the centisecond race
// timer and the winner code for the HUD and seven-segment display.
module race_controller #(
  parameter int unsigned TICK_DIV  = 1_000_000,
  parameter int unsigned LAPS      = 3,
  parameter int unsigned FIN_X_MIN = 0,
  parameter int unsigned FIN_X_MAX = 47,
  parameter int unsigned FIN_Y_MIN = 120,
  parameter int unsigned FIN_Y_MAX = 127,
  parameter int unsigned CP_X_MIN  = 272,
  parameter int unsigned CP_X_MAX  = 319,
  parameter int unsigned CP_Y_MIN  = 112,
  parameter int unsigned CP_Y_MAX  = 127
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_btn_i,
  input  logic [9:0]  p1_x_i,
  input  logic [9:0]  p1_y_i,
  input  logic [9:0]  p2_x_i,
  input  logic [9:0]  p2_y_i,
  output logic [2:0]  state_o,
  output logic [3:0]  p1_laps_o,
  output logic [3:0]  p2_laps_o,
  output logic [1:0]  winner_o,
  output logic [13:0] race_time_o,
  output logic        go_pulse_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT3   = 3'd1,
    ST_CNT2   = 3'd2,
    ST_CNT1   = 3'd3,
    ST_RACING = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  // A divider of 1 still needs a one-bit counter that simply stays at zero.
  localparam int unsigned      CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [6:0]       CS_LAST   = 7'd99;
  localparam logic [13:0]      TIME_MAX  = 14'd9999;
  localparam logic [3:0]       LAPS_Q    = 4'(LAPS);
  localparam logic [3:0]       LAPS_LAST = 4'(LAPS - 1);

  // Regions are stored as (low corner, span) so one unsigned compare covers
  // both bounds and a zero low bound needs no special case.
  localparam logic [9:0] FIN_X_LO   = 10'(FIN_X_MIN);
  localparam logic [9:0] FIN_X_SPAN = 10'(FIN_X_MAX - FIN_X_MIN);
  localparam logic [9:0] FIN_Y_LO   = 10'(FIN_Y_MIN);
  localparam logic [9:0] FIN_Y_SPAN = 10'(FIN_Y_MAX - FIN_Y_MIN);
  localparam logic [9:0] CP_X_LO    = 10'(CP_X_MIN);
  localparam logic [9:0] CP_X_SPAN  = 10'(CP_X_MAX - CP_X_MIN);
  localparam logic [9:0] CP_Y_LO    = 10'(CP_Y_MIN);
  localparam logic [9:0] CP_Y_SPAN  = 10'(CP_Y_MAX - CP_Y_MIN);

  // Inclusive range test: v - lo wraps above span whenever v < lo.
  function automatic logic in_span(input logic [9:0] v,
                                   input logic [9:0] lo,
                                   input logic [9:0] span);
    logic [9:0] off;
    off = v - lo;
    return off <= span;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [6:0]        cs_cnt_q, cs_cnt_d;
  logic [3:0]        p1_laps_q, p1_laps_d, p2_laps_q, p2_laps_d;
  logic [1:0]        winner_q, winner_d;
  logic [13:0]       race_time_q, race_time_d;
  logic              go_q, go_d;
  logic              p1_armed_q, p1_armed_d, p2_armed_q, p2_armed_d;
  logic              p1_in_fin_q, p2_in_fin_q;

  logic p1_in_fin, p2_in_fin, p1_in_cp, p2_in_cp;
  logic racing, counting, tick, cd_done;
  logic p1_lap, p2_lap, p1_done, p2_done, finish;

  assign p1_in_fin = in_span(p1_x_i, FIN_X_LO, FIN_X_SPAN) && in_span(p1_y_i, FIN_Y_LO, FIN_Y_SPAN);
  assign p2_in_fin = in_span(p2_x_i, FIN_X_LO, FIN_X_SPAN) && in_span(p2_y_i, FIN_Y_LO, FIN_Y_SPAN);
  assign p1_in_cp  = in_span(p1_x_i, CP_X_LO, CP_X_SPAN) && in_span(p1_y_i, CP_Y_LO, CP_Y_SPAN);
  assign p2_in_cp  = in_span(p2_x_i, CP_X_LO, CP_X_SPAN) && in_span(p2_y_i, CP_Y_LO, CP_Y_SPAN);

  assign racing   = (state_q == ST_RACING);
  assign counting = (state_q == ST_CNT3) || (state_q == ST_CNT2) ||
                    (state_q == ST_CNT1) || racing;
  assign tick     = (tick_cnt_q == TICK_LAST);
  assign cd_done  = tick && (cs_cnt_q == CS_LAST);

  // A lap needs a fresh entry into the finish region after a checkpoint visit.
  assign p1_lap  = racing && p1_in_fin && !p1_in_fin_q && p1_armed_q;
  assign p2_lap  = racing && p2_in_fin && !p2_in_fin_q && p2_armed_q;
  assign p1_done = p1_lap && (p1_laps_q == LAPS_LAST);
  assign p2_done = p2_lap && (p2_laps_q == LAPS_LAST);
  assign finish  = p1_done || p2_done;

  // State register and all datapath registers, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      cs_cnt_q    <= '0;
      p1_laps_q   <= '0;
      p2_laps_q   <= '0;
      winner_q    <= '0;
      race_time_q <= '0;
      go_q        <= 1'b0;
      p1_armed_q  <= 1'b0;
      p2_armed_q  <= 1'b0;
      p1_in_fin_q <= 1'b0;
      p2_in_fin_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      cs_cnt_q    <= cs_cnt_d;
      p1_laps_q   <= p1_laps_d;
      p2_laps_q   <= p2_laps_d;
      winner_q    <= winner_d;
      race_time_q <= race_time_d;
      go_q        <= go_d;
      p1_armed_q  <= p1_armed_d;
      p2_armed_q  <= p2_armed_d;
      // History follows the live region flag every cycle, so on entry to
      // RACING a player already parked on the line produces no edge.
      p1_in_fin_q <= p1_in_fin;
      p2_in_fin_q <= p2_in_fin;
    end
  end

  // Next-state logic for the race sequence
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_btn_i) state_d = ST_CNT3;
      ST_CNT3:   if (cd_done)     state_d = ST_CNT2;
      ST_CNT2:   if (cd_done)     state_d = ST_CNT1;
      ST_CNT1:   if (cd_done)     state_d = ST_RACING;
      ST_RACING: if (finish)      state_d = ST_FINISH;
      ST_FINISH: if (start_btn_i) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Tick divider and countdown centiseconds; both idle at zero outside the run
  always_comb begin
    tick_cnt_d = '0;
    cs_cnt_d   = '0;
    if (counting) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      if (!racing && tick) begin
        cs_cnt_d = (cs_cnt_q == CS_LAST) ? '0 : cs_cnt_q + 1'b1;
      end else if (!racing) begin
        cs_cnt_d = cs_cnt_q;
      end
    end
  end

  // Output logic: laps, arming, winner, race timer and go pulse
  always_comb begin
    p1_laps_d   = p1_laps_q;
    p2_laps_d   = p2_laps_q;
    winner_d    = winner_q;
    race_time_d = race_time_q;
    p1_armed_d  = 1'b0;
    p2_armed_d  = 1'b0;
    go_d        = (state_d == ST_RACING) && !racing;
    case (state_q)
      ST_IDLE: begin
        if (start_btn_i) begin
          p1_laps_d   = '0;
          p2_laps_d   = '0;
          winner_d    = '0;
          race_time_d = '0;
        end
      end
      ST_CNT1: begin
        if (state_d == ST_RACING) race_time_d = '0;
      end
      ST_RACING: begin
        // A lap event on the same edge as a checkpoint hit leaves armed clear.
        p1_armed_d = !p1_lap && (p1_armed_q || p1_in_cp);
        p2_armed_d = !p2_lap && (p2_armed_q || p2_in_cp);
        if (p1_lap && (p1_laps_q != LAPS_Q)) p1_laps_d = p1_laps_q + 1'b1;
        if (p2_lap && (p2_laps_q != LAPS_Q)) p2_laps_d = p2_laps_q + 1'b1;
        if (finish) begin
          // Bit 0 flags P1, bit 1 flags P2, both set is a tie; the timer
          // deliberately skips any tick that lands on this edge.
          winner_d = {p2_done, p1_done};
        end else if (tick && (race_time_q != TIME_MAX)) begin
          race_time_d = race_time_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign state_o     = state_q;
  assign p1_laps_o   = p1_laps_q;
  assign p2_laps_o   = p2_laps_q;
  assign winner_o    = winner_q;
  assign race_time_o = race_time_q;
  assign go_pulse_o  = go_q;

endmodule
